// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: ping-pong frame buffer; upstream fills one bank by pixel address
// while the other bank is replayed in raster order to a ready-gated streaming layer.
module fmap_stream_tx #(
    parameter int DATA_SIZE = 8,
    parameter int CHANNELS  = 256,
    parameter int IMG_DIM   = 13,
    parameter int PIX_W     = $clog2(IMG_DIM*IMG_DIM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [PIX_W-1:0]     i_wr_addr,
    input  logic [DATA_SIZE-1:0] i_wr_data [CHANNELS],
    input  logic                 i_frame_done,
    output logic                 o_ready,
    input  logic                 i_next_ready,
    output logic [DATA_SIZE-1:0] o_next_data [CHANNELS],
    output logic [CHANNELS-1:0]  o_next_we,
    output logic                 o_next_start
);
    localparam int NPIX = IMG_DIM*IMG_DIM;

    typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

    state_t               r_state, w_next;
    logic [1:0]           r_full;
    logic                 r_wr_bank, r_rd_bank;
    logic [PIX_W-1:0]     r_cnt;
    logic [DATA_SIZE-1:0] r_mem [2][NPIX][CHANNELS];
    logic                 w_wr, w_fin, w_beat, w_last;

    assign o_ready = !r_full[r_wr_bank];
    assign w_wr    = i_wr_en && o_ready && (32'(i_wr_addr) < NPIX);
    assign w_fin   = i_frame_done && o_ready;
    assign w_beat  = (r_state == STREAM) && i_next_ready;
    assign w_last  = w_beat && (32'(r_cnt) == NPIX-1);

    // Frame storage carries no reset; the full flags alone decide what is valid.
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr_bank][i_wr_addr] <= i_wr_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && r_full[r_rd_bank] && i_next_ready) ? START  :
                 (r_state == START && i_next_ready)                      ? STREAM :
                 w_last                                                  ? IDLE   : r_state;
    end

    // The fill and drain banks always differ when both events coincide, so
    // the set and the clear below never touch the same flag.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_fin) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= !r_wr_bank;
            end
            if (w_last) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= !r_rd_bank;
            end
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_cnt        <= '0;
            o_next_start <= 1'b0;
            o_next_we    <= '0;
            o_next_data  <= '{default: '0};
        end else begin
            o_next_start <= (r_state == START) && i_next_ready;
            o_next_we    <= {CHANNELS{w_beat}};
            r_cnt        <= (r_state == START) ? '0 : w_beat ? r_cnt + 1'b1 : r_cnt;
            if (w_beat) o_next_data <= r_mem[r_rd_bank][r_cnt];
        end
endmodule
